// File: rtl/imem_arb_pkg.sv
// Shared types and widths for the instruction-memory arbiter.
//   ADDR_W  : memory word-address width
//   INSTR_W : instruction / memory data width
//   state_e : arbiter FSM states
//   owner_e : which requester drives the memory port in a given cycle
package imem_arb_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 17;

    typedef enum logic [1:0] {
        StRun,
        StMovcRd,
        StLoad
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnFetch,
        OwnMovc,
        OwnLoad
    } owner_e;

endpackage

// File: rtl/imem_ld_seq.sv
// Loader burst sequencer: captures base address and word count at burst start,
// advances the write address (wrapping mod 2^16) and decrements the remaining
// count on every accepted write, and flags the burst end.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture base_i / len_i (burst start)
//   base_i     : first write address
//   len_i      : number of words in the burst
//   active_i   : arbiter is in the LOAD state
//   step_i     : a write is being issued this cycle
//   addr_o     : current write address
//   busy_o     : burst active with words still outstanding
//   done_o     : burst complete (one cycle, arbiter leaves LOAD afterwards)
module imem_ld_seq
    import imem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              active_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] rem_d, rem_q;
    logic              rem_zero;

    assign rem_zero = (rem_q == '0);

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            rem_d  = len_i;
        end else if (step_i && !rem_zero) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign busy_o = active_i && !rem_zero;
    // A zero-length burst lands here on its first LOAD cycle.
    assign done_o = active_i && rem_zero;

endmodule

// File: rtl/imem_arb.sv
// Single-port instruction memory arbiter. One owner per cycle, priority
// loader > MOVC > fetch; arbitration only happens in RUN.
//   clk, rst                 : clock, synchronous active-high reset
//   fetch_addr/instr/stall   : instruction fetch port (stall holds PC and IM_ID)
//   movc_req/addr/gnt/vld/rdata : MOVC data-read port (req held until gnt)
//   ld_start/base/len/wvalid/wdata/wready/busy/done : burst loader port
//   mem_addr/re/we/wdata/rdata  : single-port memory, 1-cycle synchronous read
module imem_arb
    import imem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_stall,
    input  logic               movc_req,
    input  logic [ADDR_W-1:0]  movc_addr,
    output logic               movc_gnt,
    output logic               movc_vld,
    output logic [INSTR_W-1:0] movc_rdata,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_base,
    input  logic [ADDR_W-1:0]  ld_len,
    input  logic               ld_wvalid,
    input  logic [INSTR_W-1:0] ld_wdata,
    output logic               ld_wready,
    output logic               ld_busy,
    output logic               ld_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata
);

    state_e             state_d, state_q;
    owner_e             owner_d, owner_q;
    logic [INSTR_W-1:0] instr_d, instr_q;

    logic              ld_load, ld_step, ld_active;
    logic [ADDR_W-1:0] ld_addr;

    imem_ld_seq u_ld_seq (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ld_load),
        .base_i   (ld_base),
        .len_i    (ld_len),
        .active_i (ld_active),
        .step_i   (ld_step),
        .addr_o   (ld_addr),
        .busy_o   (ld_busy),
        .done_o   (ld_done)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = OwnNone;
        mem_addr  = fetch_addr;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = ld_wdata;
        movc_gnt  = 1'b0;
        ld_load   = 1'b0;
        ld_step   = 1'b0;
        ld_active = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ld_start) begin
                    // Start cycle leaves the port idle; writes begin in LOAD.
                    ld_load = 1'b1;
                    owner_d = OwnLoad;
                    state_d = StLoad;
                end else if (movc_req) begin
                    mem_addr = movc_addr;
                    mem_re   = 1'b1;
                    movc_gnt = 1'b1;
                    owner_d  = OwnMovc;
                    state_d  = StMovcRd;
                end else begin
                    mem_re  = 1'b1;
                    owner_d = OwnFetch;
                end
            end
            StMovcRd: begin
                mem_re  = 1'b1;
                owner_d = OwnFetch;
                state_d = StRun;
            end
            StLoad: begin
                ld_active = 1'b1;
                owner_d   = OwnLoad;
                mem_addr  = ld_addr;
                if (ld_busy && ld_wvalid) begin
                    mem_we  = 1'b1;
                    ld_step = 1'b1;
                end
                if (ld_done) state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        // Reset aborts any in-flight operation in the same cycle.
        if (rst) begin
            mem_re    = 1'b0;
            mem_we    = 1'b0;
            movc_gnt  = 1'b0;
            ld_load   = 1'b0;
            ld_step   = 1'b0;
            ld_active = 1'b0;
        end
    end

    // The memory returns data one cycle after the fetch was issued.
    assign instr_d     = (owner_q == OwnFetch) ? mem_rdata : instr_q;
    assign fetch_instr = instr_d;
    assign fetch_stall = rst || (owner_d != OwnFetch) || (owner_q != OwnFetch);

    assign movc_vld   = (state_q == StMovcRd) && !rst;
    assign movc_rdata = mem_rdata;
    assign ld_wready  = ld_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            owner_q <= OwnNone;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb with a behavioural single-port memory.
module tb_imem_arb;

    logic        clk;
    logic        rst;
    logic [15:0] fetch_addr;
    logic [16:0] fetch_instr;
    logic        fetch_stall;
    logic        movc_req;
    logic [15:0] movc_addr;
    logic        movc_gnt;
    logic        movc_vld;
    logic [16:0] movc_rdata;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_len;
    logic        ld_wvalid;
    logic [16:0] ld_wdata;
    logic        ld_wready;
    logic        ld_busy;
    logic        ld_done;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [16:0] mem_wdata;
    logic [16:0] mem_rdata;

    logic [16:0] mem [0:65535];

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_ovl  = 0;

    imem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .fetch_stall (fetch_stall),
        .movc_req    (movc_req),
        .movc_addr   (movc_addr),
        .movc_gnt    (movc_gnt),
        .movc_vld    (movc_vld),
        .movc_rdata  (movc_rdata),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_wvalid   (ld_wvalid),
        .ld_wdata    (ld_wdata),
        .ld_wready   (ld_wready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (ld_done === 1'b1) n_done++;
        if (mem_we === 1'b1 && mem_re === 1'b1) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    logic [4:0]  wv_pat;
    logic [16:0] wr_data [5];
    logic [15:0] wr_addr [5];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 17'h1ABCD;
        mem[16'h0200] = 17'h05A5A;
        mem_rdata  = '0;
        rst        = 1'b1;
        fetch_addr = 16'h0010;
        movc_req   = 1'b0;
        movc_addr  = '0;
        ld_start   = 1'b0;
        ld_base    = '0;
        ld_len     = '0;
        ld_wvalid  = 1'b0;
        ld_wdata   = '0;

        // Reset
        next_cycle(); #1;
        chk("rst_gnt", movc_gnt, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wready", ld_wready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_vld", movc_vld, 0);

        // First cycle after reset: owner_q is NONE
        next_cycle(); rst = 1'b0; #1;
        chk("post_rst_stall", fetch_stall, 1);
        chk("post_rst_instr", fetch_instr, 17'h00000);
        chk("post_rst_re", mem_re, 1);
        chk("post_rst_addr", mem_addr, 16'h0010);

        // Idle fetch
        next_cycle(); #1;
        chk("fetch_instr", fetch_instr, 17'h1ABCD);
        chk("fetch_stall0", fetch_stall, 0);

        // MOVC read
        next_cycle(); movc_req = 1'b1; movc_addr = 16'h0200; #1;
        chk("movc_gnt", movc_gnt, 1);
        chk("movc_addr", mem_addr, 16'h0200);
        chk("movc_re", mem_re, 1);
        chk("movc_stall_t", fetch_stall, 1);
        next_cycle(); movc_req = 1'b0; #1;
        chk("movc_vld", movc_vld, 1);
        chk("movc_rdata", movc_rdata, 17'h05A5A);
        chk("movc_gnt_t1", movc_gnt, 0);
        chk("movc_stall_t1", fetch_stall, 1);
        chk("movc_instr_hold", fetch_instr, 17'h1ABCD);
        next_cycle(); #1;
        chk("movc_stall_t2", fetch_stall, 0);
        chk("movc_vld_t2", movc_vld, 0);
        chk("movc_instr_t2", fetch_instr, 17'h1ABCD);

        // Collision: loader wins, MOVC waits until after ld_done
        next_cycle();
        ld_start = 1'b1; ld_base = 16'h0100; ld_len = 16'd2;
        movc_req = 1'b1; movc_addr = 16'h0200; #1;
        chk("col_gnt_s0", movc_gnt, 0);
        chk("col_re_s0", mem_re, 0);
        chk("col_stall_s0", fetch_stall, 1);
        next_cycle(); ld_start = 1'b0; ld_wvalid = 1'b1; ld_wdata = 17'h11111; #1;
        chk("col_busy", ld_busy, 1);
        chk("col_wready", ld_wready, 1);
        chk("col_we0", mem_we, 1);
        chk("col_addr0", mem_addr, 16'h0100);
        chk("col_gnt_s1", movc_gnt, 0);
        chk("col_re_s1", mem_re, 0);
        chk("col_stall_s1", fetch_stall, 1);
        next_cycle(); ld_wdata = 17'h12222; #1;
        chk("col_we1", mem_we, 1);
        chk("col_addr1", mem_addr, 16'h0101);
        next_cycle(); ld_wdata = 17'h13333; #1;
        chk("col_done", ld_done, 1);
        chk("col_busy_off", ld_busy, 0);
        chk("col_we_done", mem_we, 0);
        chk("col_gnt_done", movc_gnt, 0);
        next_cycle(); ld_wvalid = 1'b0; #1;
        chk("col_gnt_late", movc_gnt, 1);
        chk("col_gnt_addr", mem_addr, 16'h0200);
        chk("col_done_off", ld_done, 0);
        next_cycle(); movc_req = 1'b0; #1;
        chk("col_vld", movc_vld, 1);
        chk("col_rdata", movc_rdata, 17'h05A5A);
        chk("col_mem100", mem[16'h0100], 17'h11111);
        chk("col_mem101", mem[16'h0101], 17'h12222);
        chk("col_mem102", mem[16'h0102], 17'h00000);

        // Wrap-around burst with a gap in ld_wvalid
        wv_pat     = 5'b11101;          // bit i = cycle i: 1,0,1,1,1
        wr_data[0] = 17'h10001; wr_addr[0] = 16'hFFFE;
        wr_data[1] = 17'h1DEAD; wr_addr[1] = 16'hFFFF;
        wr_data[2] = 17'h10002; wr_addr[2] = 16'hFFFF;
        wr_data[3] = 17'h10003; wr_addr[3] = 16'h0000;
        wr_data[4] = 17'h10004; wr_addr[4] = 16'h0001;
        next_cycle(); ld_start = 1'b1; ld_base = 16'hFFFE; ld_len = 16'd4; #1;
        chk("wrap_start_re", mem_re, 0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            ld_start  = 1'b0;
            ld_wvalid = wv_pat[i];
            ld_wdata  = wr_data[i];
            #1;
            chk($sformatf("wrap_we%0d", i), mem_we, wv_pat[i]);
            chk($sformatf("wrap_addr%0d", i), mem_addr, wr_addr[i]);
            chk($sformatf("wrap_done%0d", i), ld_done, 0);
        end
        next_cycle(); ld_wvalid = 1'b0; #1;
        chk("wrap_done", ld_done, 1);
        chk("wrap_we_done", mem_we, 0);
        next_cycle(); #1;
        chk("wrap_done_off", ld_done, 0);
        chk("wrap_run_re", mem_re, 1);
        chk("wrap_memFFFE", mem[16'hFFFE], 17'h10001);
        chk("wrap_memFFFF", mem[16'hFFFF], 17'h10002);
        chk("wrap_mem0000", mem[16'h0000], 17'h10003);
        chk("wrap_mem0001", mem[16'h0001], 17'h10004);

        // Zero-length burst
        next_cycle(); ld_start = 1'b1; ld_base = 16'h0400; ld_len = 16'd0; ld_wvalid = 1'b1;
        ld_wdata = 17'h1EEEE; #1;
        chk("len0_re", mem_re, 0);
        next_cycle(); ld_start = 1'b0; #1;
        chk("len0_done", ld_done, 1);
        chk("len0_we", mem_we, 0);
        chk("len0_busy", ld_busy, 0);
        next_cycle(); ld_wvalid = 1'b0; #1;
        chk("len0_done_off", ld_done, 0);
        chk("len0_run_re", mem_re, 1);
        chk("len0_mem", mem[16'h0400], 17'h00000);

        // Reset in the middle of an 8-word burst
        next_cycle(); ld_start = 1'b1; ld_base = 16'h0300; ld_len = 16'd8; #1;
        next_cycle(); ld_start = 1'b0; ld_wvalid = 1'b1; ld_wdata = 17'h13000; #1;
        chk("abort_we0", mem_we, 1);
        chk("abort_addr0", mem_addr, 16'h0300);
        next_cycle(); ld_wdata = 17'h13001; #1;
        chk("abort_we1", mem_we, 1);
        chk("abort_addr1", mem_addr, 16'h0301);
        next_cycle(); rst = 1'b1; ld_wdata = 17'h13002; #1;
        chk("abort_we_rst", mem_we, 0);
        chk("abort_busy_rst", ld_busy, 0);
        chk("abort_done_rst", ld_done, 0);
        chk("abort_wready_rst", ld_wready, 0);
        next_cycle(); rst = 1'b0; ld_wvalid = 1'b0; #1;
        chk("abort_run_re", mem_re, 1);
        chk("abort_run_addr", mem_addr, 16'h0010);
        chk("abort_busy", ld_busy, 0);
        chk("abort_stall", fetch_stall, 1);
        next_cycle(); #1;
        chk("abort_stall_off", fetch_stall, 0);
        chk("abort_instr", fetch_instr, 17'h1ABCD);
        for (int i = 0; i < 4; i++) next_cycle();
        #1;
        chk("abort_mem301", mem[16'h0301], 17'h13001);
        chk("abort_mem302", mem[16'h0302], 17'h00000);

        // Whole-run properties
        chk("done_pulses", n_done, 3);
        chk("we_re_overlap", n_ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The fetch port SHALL be: fetch_addr  in  16  PC to fetch; fetch_instr  out  17  instruction word; fetch_stall  out  1  stall for the IM_ID stage and PC.
REQ-003 The MOVC port SHALL be: movc_req  in  1  read request, held until granted; movc_addr  in  16  word address; movc_gnt  out  1  grant strobe; movc_vld  out  1  read data valid; movc_rdata  out  17  read data.
REQ-004 The loader port SHALL be: ld_start  in  1  start a burst; ld_base  in  16  first address; ld_len  in  16  word count; ld_wvalid  in  1  write data valid; ld_wdata  in  17  write data; ld_wready  out  1  accept strobe; ld_busy  out  1  burst active; ld_done  out  1  one-cycle completion pulse.
REQ-005 The memory port SHALL be: mem_addr  out  16; mem_re  out  1; mem_we  out  1; mem_wdata  out  17; mem_rdata  in  17. The memory is single-port with a 1-cycle synchronous read.

Function
REQ-006 The block SHALL be an FSM with states RUN, MOVC_RD and LOAD; the port has one owner per cycle.
REQ-007 Priority SHALL be loader > MOVC > fetch. Arbitration takes place only in RUN.
REQ-008 In RUN with neither ld_start nor movc_req asserted, the block SHALL drive mem_addr=fetch_addr and mem_re=1, and issue owner = FETCH.
REQ-009 In RUN with movc_req=1 and ld_start=0, the block SHALL drive mem_addr=movc_addr, mem_re=1 and movc_gnt=1 for exactly one cycle, then go to MOVC_RD.
REQ-010 In MOVC_RD, the block SHALL drive movc_vld=1 and movc_rdata=mem_rdata, issue a fetch as in REQ-008, and return to RUN. movc_req is ignored (movc_gnt=0) in MOVC_RD and LOAD.
REQ-011 A registered owner_q SHALL record the previous cycle's issue owner (NONE/FETCH/MOVC/LOAD).
- fetch_instr=mem_rdata when owner_q=FETCH; otherwise fetch_instr holds its last value.
REQ-012 fetch_stall SHALL be 1 whenever the current issue owner is not FETCH or owner_q is not FETCH; a MOVC therefore costs exactly 2 stall cycles.
REQ-013 In RUN with ld_start=1, the block SHALL latch ld_base and ld_len, assert ld_busy, and go to LOAD; movc_req pending in the same cycle waits.
REQ-014 ld_start SHALL be ignored while ld_busy=1.
REQ-015 In LOAD, the block SHALL drive ld_wready=1, mem_re=0 and fetch_stall=1.
- Each cycle with ld_wvalid=1: mem_we=1, mem_addr=current address, mem_wdata=ld_wdata; address increments mod 2^16 (0xFFFF wraps to 0x0000); remaining count decrements.
- ld_wvalid=0 cycles: no write, no count change.
REQ-016 After the write that brings the remaining count to 0, the block SHALL pulse ld_done=1 for one cycle, deassert ld_busy, and return to RUN in the next cycle.
REQ-017 A burst with ld_len=0 SHALL perform no writes and pulse ld_done in the cycle after ld_start.
REQ-018 mem_we and mem_re SHALL never both be 1 in the same cycle.

Reset
REQ-019 When rst=1, the block SHALL enter state RUN and set owner_q=NONE.
- All counters and latched addresses: 0.
- fetch_instr: 17'h00000 (LLB R0,#0).
- movc_gnt, movc_vld, ld_busy, ld_done, ld_wready, mem_we: 0.
REQ-020 A reset asserted during MOVC_RD or LOAD SHALL abort the operation: no further mem_we, no ld_done, no movc_vld.
REQ-021 In the first cycle after reset, fetch_stall SHALL be 1 because owner_q=NONE.

Structure
REQ-022 The shared package SHALL hold: ADDR_W=16, INSTR_W=17, the state enum {RUN, MOVC_RD, LOAD}, and the owner enum {NONE, FETCH, MOVC, LOAD}.
REQ-023 The loader address/count logic SHALL be one sub-module, imem_ld_seq, containing base latch, incrementer, remaining count and done generation.

Verification
REQ-024 Idle fetch: fetch_addr=0x0010, mem_rdata=0x1ABCD → fetch_instr=0x1ABCD one cycle later; fetch_stall=0 from the 2nd cycle after reset.
REQ-025 MOVC: movc_req with movc_addr=0x0200 → movc_gnt in cycle T with mem_addr=0x0200; movc_vld in T+1 with movc_rdata=memory[0x0200]; fetch_stall=1 in T and T+1 only.
REQ-026 Collision: ld_start and movc_req in the same cycle → LOAD wins; movc_gnt is issued only after ld_done and return to RUN.
REQ-027 Wrap: ld_base=0xFFFE, ld_len=4, ld_wvalid gapped (1,0,1,1,1) → writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001; ld_done once after the 4th write.
REQ-028 Corner and reset cases:
- ld_len=0 → ld_done in the next cycle, mem_we never set.
- rst asserted after the 2nd write of an 8-word burst → mem_we=0 and ld_busy=0 immediately, no ld_done, RUN resumes.
